// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - access size encodings (SIZE_BYTE / SIZE_HALF / SIZE_WORD; 2'b11 behaves as a word)
//   - responder FSM state enum
//   - byte-enable, store-lane, load-extension and misalignment helpers
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Lanes touched by an access. Half accesses use addr[1] only and word
    // accesses use every lane, so misaligned offsets fall back to the
    // naturally aligned container.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across the word; the byte enables
    // then pick the lane(s) that actually get written.
    function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                                input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{data[7:0]}};
            SIZE_HALF: lanes = {2{data[15:0]}};
            default:   lanes = data;
        endcase
        return lanes;
    endfunction

    // Pull the addressed byte/half out of a RAM word and extend it.
    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic [1:0]  offset,
                                                input logic        is_unsigned,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(word >> {offset, 3'b000});
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: res = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_HALF: res = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default:   res = word;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            default:   mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the core's data-memory
// port (master) and the responder (slave).
//   req_valid_i/req_ready_o        request handshake
//   we_i, size_i, unsigned_i       access kind
//   data_mem_address_i             byte address
//   data_mem_write_i               right-aligned store data
//   rsp_valid_o                    one-cycle response strobe
//   data_mem_read_o, rsp_err_o     response payload, valid with rsp_valid_o
//
// Handshake: a request transfers on a rising clk edge where req_valid_i and
// req_ready_o are both 1; the master keeps the request fields stable while
// req_valid_i is high and ready is low. Responses have no back-pressure:
// rsp_valid_o is high for exactly one cycle and the payload stays on
// data_mem_read_o/rsp_err_o until the next response.
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] data_mem_address_i;
    logic [31:0] data_mem_write_i;
    logic        rsp_valid_o;
    logic [31:0] data_mem_read_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, we_i, size_i, unsigned_i,
               data_mem_address_i, data_mem_write_i,
        input  req_ready_o, rsp_valid_o, data_mem_read_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, we_i, size_i, unsigned_i,
               data_mem_address_i, data_mem_write_i,
        output req_ready_o, rsp_valid_o, data_mem_read_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: 2^ADDR_WIDTH x 32 synchronous RAM.
//   clk    clock
//   addr   word address
//   be     per-byte write enables (lane i = bits [8i+7:8i])
//   wdata  write data, already lane-aligned
//   re     read enable; rdata is registered on the same edge
//   rdata  registered read data
// Contents are not reset.
module dmem_byte_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32IM pipeline. Accepts one
// load/store at a time, optionally inserts WAIT_STATES idle cycles, then
// performs a byte-enabled write or an extended load against dmem_byte_ram.
//   clk, rst     clock, synchronous active-high reset
//   bus          dmem_responder_if slave port (request + response)
//   dbg_state    current FSM state
// Parameters: ADDR_WIDTH (word-address bits), WAIT_STATES (0..15).
// Build option: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses with rsp_err_o (no RAM write, zero data); otherwise misaligned
// offsets are aligned down and rsp_err_o is tied 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus,
    output state_t          dbg_state
);
    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state;
    state_t                state_next;
    logic                  req_ready;
    logic                  rsp_valid;
    logic                  accept;

    logic [3:0]            cnt;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;

    logic                  misaligned;
    logic [3:0]            ram_be;
    logic                  ram_re;
    logic [31:0]           ram_rdata;
    logic [31:0]           rsp_data;
    logic [31:0]           data_hold;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid_i) begin
                    if (HAS_WAIT) begin
                        state_next = WAIT;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && bus.req_valid_i;

    // ------------------------------------------------------------------
    // Request capture and wait-state counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
        end else begin
            if (accept) begin
                // Only the in-RAM byte address is kept: upper bits wrap.
                addr_q     <= bus.data_mem_address_i[ADDR_WIDTH+1:0];
                wdata_q    <= bus.data_mem_write_i;
                we_q       <= bus.we_i;
                size_q     <= bus.size_i;
                unsigned_q <= bus.unsigned_i;
                cnt        <= WAIT_LOAD;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(size_q, addr_q[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // RAM access. The write is gated by rst so a reset landing on the
    // ACCESS cycle still drops the store.
    // ------------------------------------------------------------------
    assign ram_be = ((state == ACCESS) && we_q && !misaligned && !rst)
                    ? byte_enable(size_q, addr_q[1:0]) : 4'b0000;
    assign ram_re = (state == ACCESS) && !we_q;

    dmem_byte_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .addr  (addr_q[ADDR_WIDTH+1:2]),
        .be    (ram_be),
        .wdata (store_lanes(size_q, wdata_q)),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Response. The RAM word is only available in RESP, so the payload is
    // taken combinationally there and copied into a hold register that
    // drives the outputs until the next response.
    // ------------------------------------------------------------------
    assign rsp_data = (we_q || misaligned)
                      ? 32'd0 : load_extend(size_q, addr_q[1:0], unsigned_q, ram_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_hold <= 32'd0;
        end else if (state == RESP) begin
            data_hold <= rsp_data;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_hold <= 1'b0;
        end else if (state == RESP) begin
            err_hold <= misaligned;
        end
    end

    assign bus.rsp_err_o = (state == RESP) ? misaligned : err_hold;
`else
    assign bus.rsp_err_o = 1'b0;
`endif

    assign bus.req_ready_o     = req_ready;
    assign bus.rsp_valid_o     = rsp_valid;
    assign bus.data_mem_read_o = (state == RESP) ? rsp_data : data_hold;
    assign dbg_state           = state;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder. Two instances
// share clk/rst: index 0 has WAIT_STATES=0, index 1 has WAIT_STATES=3.
// Expected data comes from a byte-addressed reference memory per instance.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Per-instance drive and observe signals (index = instance).
    logic        req_valid [2];
    logic        we        [2];
    logic [1:0]  size      [2];
    logic        unsgn     [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic        ready     [2];
    logic        rsp_valid [2];
    logic [31:0] rdata     [2];
    logic        err       [2];
    state_t      st        [2];

    int ws_cfg [2] = '{0, 3};

    dmem_responder_if bus0 ();
    dmem_responder_if bus3 ();

    assign bus0.req_valid_i        = req_valid[0];
    assign bus0.we_i               = we[0];
    assign bus0.size_i             = size[0];
    assign bus0.unsigned_i         = unsgn[0];
    assign bus0.data_mem_address_i = addr[0];
    assign bus0.data_mem_write_i   = wdata[0];
    assign ready[0]                = bus0.req_ready_o;
    assign rsp_valid[0]            = bus0.rsp_valid_o;
    assign rdata[0]                = bus0.data_mem_read_o;
    assign err[0]                  = bus0.rsp_err_o;

    assign bus3.req_valid_i        = req_valid[1];
    assign bus3.we_i               = we[1];
    assign bus3.size_i             = size[1];
    assign bus3.unsigned_i         = unsgn[1];
    assign bus3.data_mem_address_i = addr[1];
    assign bus3.data_mem_write_i   = wdata[1];
    assign ready[1]                = bus3.req_ready_o;
    assign rsp_valid[1]            = bus3.rsp_valid_o;
    assign rdata[1]                = bus3.data_mem_read_o;
    assign err[1]                  = bus3.rsp_err_o;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0),
        .dbg_state (st[0])
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus3),
        .dbg_state (st[1])
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic        err_q [$];
    logic [7:0]  mdl [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 4 KiB of byte storage per instance; addresses wrap modulo 4096.
    function automatic int bidx(input int d, input logic [31:0] a);
        return d * 4096 + int'(a[11:0]);
    endfunction

    task automatic model_req(input int d, input logic w, input logic [1:0] sz,
                             input logic u, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] ed, output logic ee);
        int          n;
        logic [31:0] base;
        logic [31:0] val;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = a - (a % 32'(n));
        ee   = 1'b0;
        ed   = 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
        ee = (base != a);
`endif
        if (ee) return;
        if (w) begin
            for (int i = 0; i < n; i++) begin
                mdl[bidx(d, base + 32'(i))] = 8'(wd >> (8 * i));
            end
        end else begin
            val = 32'd0;
            for (int i = 0; i < n; i++) begin
                val = val | (32'(mdl[bidx(d, base + 32'(i))]) << (8 * i));
            end
            if (!u && n < 4 && val[8*n-1]) begin
                val = val | ~((32'd1 << (8 * n)) - 32'd1);
            end
            ed = val;
        end
    endtask

    // Issue one request on instance d and check latency, payload and the
    // one-cycle strobe with held payload afterwards.
    task automatic do_req(input int d, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic [31:0] ed;
        logic        ee;
        logic [31:0] exp_data;
        logic        exp_err;
        int          tries;
        int          edges;
        bit          got;
        model_req(d, w, sz, u, a, wd, ed, ee);
        exp_q.push_back(ed);
        err_q.push_back(ee);
        @(negedge clk);
        we[d] = w; size[d] = sz; unsgn[d] = u; addr[d] = a; wdata[d] = wd;
        req_valid[d] = 1'b1;
        tries = 0;
        while (!ready[d] && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        got   = 1'b0;
        edges = 0;
        while (!got && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            got = rsp_valid[d];
        end
        exp_data = exp_q.pop_front();
        exp_err  = err_q.pop_front();
        chk({tag, " lat"}, got ? 32'(edges) : 32'hFFFF_FFFF, 32'(1 + ws_cfg[d]));
        chk({tag, " data"}, rdata[d], exp_data);
        chk({tag, " err"}, {31'b0, err[d]}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        chk({tag, " strobe"}, {31'b0, rsp_valid[d]}, 32'd0);
        chk({tag, " hold"}, rdata[d], exp_data);
    endtask

    initial begin
        int          acc [$];
        int          tries;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        w;
        logic        u;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; we[d] = 1'b0; size[d] = 2'd0;
            unsgn[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0;
        end

        // Clock/reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset ready", {31'b0, ready[d]}, 32'd1);
            chk("reset rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
            chk("reset data", rdata[d], 32'd0);
            chk("reset err", {31'b0, err[d]}, 32'd0);
            chk("reset state", 32'(st[d]), 32'(IDLE));
        end

        // Directed: word, byte, half on the zero-wait instance.
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw 0x10");
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw 0x10");
        chk("lw 0x10 const", rdata[0], 32'hDEADBEEF);
        do_req(0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, "sb 0x13");
        do_req(0, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lb 0x13");
        chk("lb 0x13 const", rdata[0], 32'hFFFFFF80);
        do_req(0, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "lbu 0x13");
        chk("lbu 0x13 const", rdata[0], 32'h00000080);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw 0x10 after sb");
        chk("lw 0x10 after sb const", rdata[0], 32'h80ADBEEF);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, "lw wrap 0x1010");
        chk("lw wrap const", rdata[0], 32'h80ADBEEF);
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, "sw 0x20");
        do_req(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h8001, "sh 0x22");
        do_req(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "lh 0x22");
        chk("lh 0x22 const", rdata[0], 32'hFFFF8001);
        do_req(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "lhu 0x22");
        chk("lhu 0x22 const", rdata[0], 32'h00008001);
        do_req(0, 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, "lhu 0x20");
        chk("lhu 0x20 const", rdata[0], 32'h00003344);

        // Misaligned word store.
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h14, 32'hA5A5A5A5, "sw 0x14");
        do_req(0, 1'b1, 2'd2, 1'b0, 32'h15, 32'h12345678, "sw 0x15");
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misaligned err const", {31'b0, err[0]}, 32'd1);
`else
        chk("misaligned err const", {31'b0, err[0]}, 32'd0);
`endif
        do_req(0, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, "lw 0x14");
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lw 0x14 const", rdata[0], 32'hA5A5A5A5);
`else
        chk("lw 0x14 const", rdata[0], 32'h12345678);
`endif

        // Randomized traffic on both instances inside a prefilled window.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_req(d, 1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), $urandom, "fill");
            end
            for (int i = 0; i < 50; i++) begin
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                u  = 1'($urandom_range(0, 1));
                a  = 32'h100 + 32'($urandom_range(0, 63));
                a[19:12] = 8'($urandom_range(0, 255));
                do_req(d, w, sz, u, a, $urandom, "rand");
            end
        end

        // Throughput with req_valid held high on the 3-wait instance.
        @(negedge clk);
        we[1] = 1'b0; size[1] = 2'd2; unsgn[1] = 1'b0; addr[1] = 32'h100;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            if (ready[1]) acc.push_back(c);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("thru accepts", 32'(acc.size()), 32'd4);
        for (int k = 1; k < acc.size(); k++) begin
            chk("thru gap", 32'(acc[k] - acc[k-1]), 32'd6);
        end
        repeat (10) @(posedge clk);

        // Reset during WAIT drops a pending store.
        do_req(1, 1'b1, 2'd2, 1'b0, 32'h34, 32'hCAFEF00D, "sw 0x34");
        do_req(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, "sw 0x30");
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h34, 32'h0, "lw 0x34");
        @(negedge clk);
        we[1] = 1'b1; size[1] = 2'd2; unsgn[1] = 1'b0;
        addr[1] = 32'h30; wdata[1] = 32'hFFFFFFFF;
        req_valid[1] = 1'b1;
        tries = 0;
        while (!ready[1] && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        chk("rst pre state", 32'(st[1]), 32'(WAIT));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst ready", {31'b0, ready[1]}, 32'd1);
        chk("rst rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
        chk("rst data", rdata[1], 32'd0);
        chk("rst err", {31'b0, err[1]}, 32'd0);
        chk("rst state", 32'(st[1]), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "lw 0x30 after rst");
        chk("lw 0x30 const", rdata[1], 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
